display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Scan controller for the three-digit seven-segment display. It converts a 10-bit binary value into hundreds/tens/units BCD with a sequential shift-add-3 engine. It then time-multiplexes the digits onto one shared DecoDisplay instance, driving the decoder's `numeroDCU` input and the active-low digit anodes. It sits between the application value source and the decoder/display pins.

## Interface
- `PRESC_W`, default 16: prescaler width; each digit stays lit for 2^PRESC_W clock cycles.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `valor`  input  10  binary value to display, 0–999 valid; sampled only on an accepted `cargar`.
- `cargar`  input  1  load strobe; accepted only when `busy`=0.
- `numeroDCU`  output  4  digit code to DecoDisplay: BCD 0–9, or 4'hF for a blank digit.
- `anodo`  output  3  active-low one-hot anode select: [0]=units, [1]=tens, [2]=hundreds.
- `busy`  output  1  conversion in progress.
- `listo`  output  1  one-cycle pulse when a new value is committed to the display.
- `error`  output  1  last committed value was greater than 999.

## Operation
- Conversion FSM has three states: IDLE, CONV, COMMIT.
  - IDLE: on `cargar`=1, capture `valor` into a 10-bit shift register, clear the 12-bit BCD accumulator and the 4-bit iteration count, go to CONV.
  - CONV: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,bin} left by 1. After the 10th shift, go to COMMIT.
  - COMMIT: update the display registers (cent/dec/uni), update `error`, pulse `listo`, return to IDLE.
- Range check: if the captured value is greater than 999, set cent=dec=uni=4'hF and `error`=1. Otherwise load the BCD digits and set `error`=0. `error` holds until the next commit.
- `cargar` while `busy`=1 is ignored; there is no queueing.
- During conversion the display keeps scanning the previously committed digits, so there is no flicker or intermediate values.
- Scan:
  - The PRESC_W-bit prescaler counts freely and wraps.
  - `tick` is asserted when the prescaler is all ones.
  - On `tick`, the 2-bit `sel` advances 0→1→2→0. Value 3 is unreachable; if it ever occurs, treat it as 0.
- `anodo` and `numeroDCU` are combinational decodes of the registered `sel`, display registers and blanking logic.
  - sel=0: `anodo`=3'b110, `numeroDCU`=uni.
  - sel=1: `anodo`=3'b101, `numeroDCU`=dec.
  - sel=2: `anodo`=3'b011, `numeroDCU`=cent.
- Reset: state=IDLE, prescaler=0, `sel`=0, cent=dec=uni=0, `busy`=0, `listo`=0, `error`=0. The resulting outputs are `anodo`=3'b110 and `numeroDCU`=4'h0.

## Timing
- Let E0 be the edge at which `cargar` is sampled high in IDLE.
  - Shifts occur on edges E1–E10.
  - Commit occurs on E11: display registers, `error` and `listo` are registered on that edge.
- `busy` is high for the 11 cycles following E0 (E0 through E11). `listo` is high for the single cycle following E11.
- A `cargar` sampled at E12 is accepted. This is the earliest possible back-to-back load, coincident with the `listo` cycle.
- A commit takes effect on the currently lit digit immediately; it does not wait for a `tick`.
- Reset asserted mid-conversion:
  - Conversion is aborted on that edge; no `listo` is generated.
  - The display returns to 0.
  - Reset overrides a simultaneous `cargar`.
- The prescaler and `sel` run independently of the FSM; the scan period is 3·2^PRESC_W cycles.

## Configuration
- `BLANK_LEADING_ZEROS_EN` defined: leading-zero suppression.
  - cent=0 displays as 4'hF.
  - If cent=0 and dec=0, dec also displays as 4'hF.
  - uni is always shown.
  - The error state (all 4'hF) is unaffected.
- `BLANK_LEADING_ZEROS_EN` undefined: all three digits are always shown as stored. Reset shows "000".

## Test plan
- Reset with PRESC_W=4 → `anodo`=110, `numeroDCU`=0, `busy`=0, `error`=0; `anodo` steps 110→101→011→110 every 16 cycles.
- `cargar` with `valor`=725 → `busy` high for exactly 11 cycles, one `listo` pulse at E11+1 → scan shows 5/2/7 on anodes 110/101/011.
- `valor`=1000, then `valor`=999 → first load gives `error`=1 and `numeroDCU`=F on every digit; second gives `error`=0 and digits 9/9/9.
- `cargar` with `valor`=725, then `cargar` with `valor`=300 two cycles later → second load ignored; display 725, single `listo`.
- `valor`=7 → without macro, digits 0/0/7; with `BLANK_LEADING_ZEROS_EN`, F/F/7. `valor`=105 with the macro → 1/0/5 (inner zero kept).
- Load 725, then assert `reset` at E5 of a load of 300 → `busy`=0 next cycle, no `listo`, display 000, `sel`=0.

Source files
------------

// File: rtl/display_scan_ctrl_if.sv
// Value-load handshake and display-pin bundle between the value source, display_scan_ctrl and DecoDisplay.
interface display_scan_ctrl_if;
  logic [9:0] valor;
  logic       cargar;
  logic [3:0] numeroDCU;
  logic [2:0] anodo;
  logic       busy;
  logic       listo;
  logic       error;

  modport master (
    output valor, cargar,
    input  numeroDCU, anodo, busy, listo, error
  );

  modport slave (
    input  valor, cargar,
    output numeroDCU, anodo, busy, listo, error
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Three-digit 7-segment scan controller: sequential binary-to-BCD conversion plus anode multiplexing.
// Optional feature: define BLANK_LEADING_ZEROS_EN to suppress leading zeros on the display.
module display_scan_ctrl #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  display_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  localparam logic [3:0] BLANK = 4'hF;

  state_t             state_q, state_d;
  logic [9:0]         bin_q, bin_d;
  logic [11:0]        bcd_q, bcd_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               over_q, over_d;
  logic [3:0]         cent_q, cent_d, dec_q, dec_d, uni_q, uni_d;
  logic               busy_q, busy_d;
  logic               listo_q, listo_d;
  logic               error_q, error_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [1:0]         sel_q, sel_d;

  logic [11:0] bcd_adj;
  logic        tick;

  // NOTE: always_comb uses blocking assignments so later statements see earlier updates;
  // the nibble loop relies on this to build the corrected accumulator in one pass.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    over_d  = over_q;
    cent_d  = cent_q;
    dec_d   = dec_q;
    uni_d   = uni_q;
    error_d = error_q;
    listo_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cargar) begin
          bin_d   = bus.valor;
          bcd_d   = '0;
          cnt_d   = '0;
          over_d  = (bus.valor > 10'd999);
          state_d = CONV;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {bcd_adj[10:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == 4'd9) state_d = COMMIT;
      end
      COMMIT: begin
        // Out-of-range values blank every digit rather than show a truncated BCD result.
        if (over_q) begin
          cent_d  = BLANK;
          dec_d   = BLANK;
          uni_d   = BLANK;
          error_d = 1'b1;
        end else begin
          cent_d  = bcd_q[11:8];
          dec_d   = bcd_q[7:4];
          uni_d   = bcd_q[3:0];
          error_d = 1'b0;
        end
        listo_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Scan timing is free-running and independent of the conversion FSM.
  assign tick = &presc_q;

  always_comb begin
    presc_d = presc_q + 1'b1;
    sel_d   = sel_q;
    if (tick) begin
      case (sel_q)
        2'd0:    sel_d = 2'd1;
        2'd1:    sel_d = 2'd2;
        default: sel_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      over_q  <= 1'b0;
      cent_q  <= '0;
      dec_q   <= '0;
      uni_q   <= '0;
      busy_q  <= 1'b0;
      listo_q <= 1'b0;
      error_q <= 1'b0;
      presc_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      over_q  <= over_d;
      cent_q  <= cent_d;
      dec_q   <= dec_d;
      uni_q   <= uni_d;
      busy_q  <= busy_d;
      listo_q <= listo_d;
      error_q <= error_d;
      presc_q <= presc_d;
      sel_q   <= sel_d;
    end
  end

  logic [3:0] disp_cent, disp_dec;

`ifdef BLANK_LEADING_ZEROS_EN
  always_comb begin
    disp_cent = (cent_q == 4'd0) ? BLANK : cent_q;
    disp_dec  = (cent_q == 4'd0 && dec_q == 4'd0) ? BLANK : dec_q;
  end
`else
  always_comb begin
    disp_cent = cent_q;
    disp_dec  = dec_q;
  end
`endif

  always_comb begin
    case (sel_q)
      2'd1: begin
        bus.anodo     = 3'b101;
        bus.numeroDCU = disp_dec;
      end
      2'd2: begin
        bus.anodo     = 3'b011;
        bus.numeroDCU = disp_cent;
      end
      default: begin
        bus.anodo     = 3'b110;
        bus.numeroDCU = uni_q;
      end
    endcase
  end

  assign bus.busy  = busy_q;
  assign bus.listo = listo_q;
  assign bus.error = error_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: vector table of loads plus multi-cycle corner sequences.
module tb_display_scan_ctrl;

  localparam int PRESC_W = 4;
  localparam int DIGIT_CYCLES = 16;

  logic clk;
  logic reset;
  display_scan_ctrl_if bus ();

  display_scan_ctrl #(.PRESC_W(PRESC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0] valor;
    logic       err;
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] u;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [3:0] shown_cent(input logic [3:0] c);
`ifdef BLANK_LEADING_ZEROS_EN
    return (c == 4'd0) ? 4'hF : c;
`else
    return c;
`endif
  endfunction

  function automatic logic [3:0] shown_dec(input logic [3:0] c, input logic [3:0] d);
`ifdef BLANK_LEADING_ZEROS_EN
    return (c == 4'd0 && d == 4'd0) ? 4'hF : d;
`else
    return d;
`endif
  endfunction

  task automatic wait_anodo(input logic [2:0] target, output int n);
    n = 0;
    while (bus.anodo !== target && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_digits(input string name, input logic [3:0] c, input logic [3:0] d,
                              input logic [3:0] u);
    int n;
    wait_anodo(3'b110, n);
    check({name, " uni"}, bus.numeroDCU, u);
    wait_anodo(3'b101, n);
    check({name, " dec"}, bus.numeroDCU, shown_dec(c, d));
    wait_anodo(3'b011, n);
    check({name, " cent"}, bus.numeroDCU, shown_cent(c));
    check({name, " anode wait"}, (n < 100), 1'b1);
  endtask

  task automatic do_load(input logic [9:0] v, output int nbusy, output int nlisto,
                         output int listo_at);
    @(negedge clk);
    bus.valor  = v;
    bus.cargar = 1'b1;
    @(negedge clk);
    bus.cargar = 1'b0;
    nbusy    = 0;
    nlisto   = 0;
    listo_at = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy) nbusy++;
      if (bus.listo) begin
        nlisto++;
        if (listo_at < 0) listo_at = i;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int nb, nl, la, n;

    vecs[0] = '{10'd725,  1'b0, 4'd7, 4'd2, 4'd5};
    vecs[1] = '{10'd1000, 1'b1, 4'hF, 4'hF, 4'hF};
    vecs[2] = '{10'd999,  1'b0, 4'd9, 4'd9, 4'd9};
    vecs[3] = '{10'd7,    1'b0, 4'd0, 4'd0, 4'd7};
    vecs[4] = '{10'd105,  1'b0, 4'd1, 4'd0, 4'd5};
    vecs[5] = '{10'd0,    1'b0, 4'd0, 4'd0, 4'd0};
    vecs[6] = '{10'd1023, 1'b1, 4'hF, 4'hF, 4'hF};
    vecs[7] = '{10'd100,  1'b0, 4'd1, 4'd0, 4'd0};
    vecs[8] = '{10'd50,   1'b0, 4'd0, 4'd5, 4'd0};

    bus.valor  = '0;
    bus.cargar = 1'b0;
    reset      = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset anodo", bus.anodo, 3'b110);
    check("reset digit", bus.numeroDCU, 4'h0);
    check("reset busy", bus.busy, 1'b0);
    check("reset listo", bus.listo, 1'b0);
    check("reset error", bus.error, 1'b0);

    wait_anodo(3'b101, n);
    check("scan first step", bus.anodo, 3'b101);
    @(negedge clk);
    wait_anodo(3'b011, n);
    check("scan 101->011 cycles", n + 1, DIGIT_CYCLES);
    @(negedge clk);
    wait_anodo(3'b110, n);
    check("scan 011->110 cycles", n + 1, DIGIT_CYCLES);

    foreach (vecs[i]) begin
      do_load(vecs[i].valor, nb, nl, la);
      check($sformatf("v%0d busy cycles", vecs[i].valor), nb, 11);
      check($sformatf("v%0d listo count", vecs[i].valor), nl, 1);
      check($sformatf("v%0d listo position", vecs[i].valor), la, 11);
      check($sformatf("v%0d error", vecs[i].valor), bus.error, vecs[i].err);
      check_digits($sformatf("v%0d", vecs[i].valor), vecs[i].c, vecs[i].d, vecs[i].u);
    end

    // A load issued while busy must be dropped entirely.
    @(negedge clk);
    bus.valor  = 10'd725;
    bus.cargar = 1'b1;
    @(negedge clk);
    bus.cargar = 1'b0;
    @(negedge clk);
    bus.valor  = 10'd300;
    bus.cargar = 1'b1;
    @(negedge clk);
    bus.cargar = 1'b0;
    nl = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.listo) nl++;
      @(negedge clk);
    end
    check("ignored load listo count", nl, 1);
    check("ignored load busy", bus.busy, 1'b0);
    check_digits("ignored load", 4'd7, 4'd2, 4'd5);

    // Back-to-back: a load presented in the listo cycle is accepted.
    @(negedge clk);
    bus.valor  = 10'd100;
    bus.cargar = 1'b1;
    @(negedge clk);
    bus.cargar = 1'b0;
    n = 0;
    while (!bus.listo && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("b2b listo seen", bus.listo, 1'b1);
    check("b2b busy low in listo", bus.busy, 1'b0);
    bus.valor  = 10'd42;
    bus.cargar = 1'b1;
    @(negedge clk);
    bus.cargar = 1'b0;
    check("b2b second accepted", bus.busy, 1'b1);
    repeat (12) @(negedge clk);
    check_digits("b2b", 4'd0, 4'd4, 4'd2);

    // Reset at E5 of a conversion aborts it and clears the display.
    @(negedge clk);
    bus.valor  = 10'd300;
    bus.cargar = 1'b1;
    @(negedge clk);
    bus.cargar = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort busy", bus.busy, 1'b0);
    check("abort listo", bus.listo, 1'b0);
    check("abort anodo", bus.anodo, 3'b110);
    check("abort digit", bus.numeroDCU, 4'h0);
    reset = 1'b0;
    nl = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.listo || bus.busy) nl++;
      @(negedge clk);
    end
    check("abort no activity", nl, 0);
    check_digits("abort", 4'd0, 4'd0, 4'd0);

    // Reset wins over a simultaneous load.
    @(negedge clk);
    reset      = 1'b1;
    bus.valor  = 10'd555;
    bus.cargar = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    bus.cargar = 1'b0;
    check("reset vs cargar busy", bus.busy, 1'b0);
    repeat (15) @(negedge clk);
    check("reset vs cargar idle", bus.busy, 1'b0);
    check_digits("reset vs cargar", 4'd0, 4'd0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
